prog_loader_rx: RTL
===================

PROG_LOADER_RX -- requirements
Module: prog_loader_rx

Interface
REQ-001 Parameter DATA_W, default 8, width of one memory word in bits.
REQ-002 Parameter DEPTH, default 16, number of words per load; power of two, 2..256.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), width of the write address.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode_in  input  2  loader command: 00 idle, 01 load instruction memory, 10 load data memory, 11 run.
REQ-007 mosi_in  input  1  serial data, MSB-first, one bit per clk.
REQ-008 we_o  output  1  one-cycle memory write strobe.
REQ-009 wsel_o  output  1  write target: 0 instruction memory, 1 data memory.
REQ-010 waddr_o  output  ADDR_W  write address.
REQ-011 wdata_o  output  DATA_W  write data.
REQ-012 busy_o  output  1  high while in SHIFT.
REQ-013 done_o  output  1  high while in DONE.
REQ-014 run_o  output  1  high while in RUN; processor core is enabled only when high.

Function
REQ-015 The FSM SHALL have the states IDLE, SHIFT, DONE and RUN; all outputs are registered.
REQ-016 In IDLE, mode_in 01 or 10 SHALL move the FSM to SHIFT on the next edge, with wsel_o = mode_in[1], address counter 0 and bit counter 0.
REQ-017 In IDLE, mode_in 11 SHALL move the FSM to RUN; mode_in 00 SHALL keep it in IDLE.
REQ-018 In SHIFT, every edge SHALL shift mosi_in into the LSB of the shift register, so the first bit received becomes the MSB of the word.
REQ-019 The first sampled bit SHALL be mosi_in during the first cycle in which the FSM is in SHIFT, which is the second consecutive cycle with mode_in = 01 or 10.
REQ-020 On the edge capturing bit DATA_W-1 of a word, the block SHALL register the full word into wdata_o and the current address into waddr_o, and set we_o high for exactly the following cycle.
REQ-021 On that same edge the bit counter SHALL reset to 0 and the address counter SHALL increment, so words stream back-to-back with no gap cycles.
REQ-022 When word DEPTH-1 is written, the FSM SHALL enter DONE; the address counter wraps to 0 and no further bits are sampled.
REQ-023 The final we_o pulse and done_o rising SHALL occur in the same cycle.
REQ-024 The latency from the first bit of word k to its we_o pulse SHALL be DATA_W cycles.
REQ-025 In DONE, mode_in 00 SHALL move the FSM to IDLE, mode_in 11 SHALL move it to RUN, and 01/10 SHALL hold it in DONE, so a load cannot restart without passing through idle.
REQ-026 In SHIFT, a mode_in change away from the value latched at entry SHALL abort on the next edge:
  - the FSM goes to IDLE, or to RUN if mode_in is 11;
  - the partial word is discarded, with no we_o;
  - done_o stays 0.
REQ-027 If an abort coincides with the edge that completes a word, the word SHALL NOT be written.
REQ-028 In RUN, mode_in other than 11 SHALL return the FSM to IDLE on the next edge; run_o falls in the same cycle.
REQ-029 Outside the we_o cycle, wdata_o and waddr_o SHALL hold their last written values.
REQ-030 we_o SHALL never be high in IDLE, DONE or RUN, except for the single cycle required by REQ-023.

Reset
REQ-031 rst SHALL force the FSM to IDLE and clear the following to 0: we_o, wsel_o, waddr_o, wdata_o, busy_o, done_o, run_o, the shift register and both counters.
REQ-032 rst SHALL take priority over every other input, including mid-word and on the edge of a word's completion.
REQ-033 After rst is released, loading SHALL require mode_in to pass through IDLE entry per REQ-016.

Verification
- Instruction load: DEPTH=16, mode_in=01, stream bytes 0x00..0x0F MSB-first -> 16 we_o pulses, waddr_o 0..15, wdata_o = address, wsel_o=0, done_o rises together with the 16th we_o.
- Data load timing: mode_in=10, first byte 0xA5 -> we_o exactly 8 cycles after the first sampled bit, wdata_o=0xA5, waddr_o=0, wsel_o=1, busy_o=1 throughout.
- Abort: mode_in drops 01->00 after 3 full bytes plus 5 bits -> exactly 3 we_o pulses, FSM in IDLE, done_o=0; a reload restarts at waddr_o=0.
- Done hold: mode_in held at 01 after DONE for 20 cycles -> no we_o, done_o=1; then 00 -> done_o=0; then 11 -> run_o=1 after one edge.
- Reset mid-word: rst asserted on the edge of a byte's 8th bit -> no we_o, all outputs 0 the next cycle.
- Run path: mode_in 00->11->00 -> run_o high for exactly the cycles following each edge on which mode_in=11 was sampled.

Source files
------------

// File: rtl/prog_loader_rx.sv
// Serial program/data loader: shifts MSB-first words off mosi_in and writes them
// into instruction or data memory, then hands control to the core via run_o.
module prog_loader_rx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_in,
  input  logic              mosi_in,
  output logic              we_o,
  output logic              wsel_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              run_o,
  output logic [1:0]        dbg_state_o
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_INSTR = 2'b01;
  localparam logic [1:0] M_DATA  = 2'b10;
  localparam logic [1:0] M_RUN   = 2'b11;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bitcnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_wsel;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_run;

  logic [DATA_W-1:0] w_shift_next;
  logic [1:0]        w_load_mode;
  logic              w_word_end;
  logic              w_last_word;

  // The mode latched at SHIFT entry is fully recoverable from wsel (01 or 10).
  assign w_load_mode  = {r_wsel, ~r_wsel};
  assign w_shift_next = {r_shift[DATA_W-2:0], mosi_in};
  assign w_word_end   = (r_bitcnt == BIT_W'(DATA_W - 1));
  assign w_last_word  = (r_addr == ADDR_W'(DEPTH - 1));

  // we_o is a one-cycle strobe with no ready/backpressure: the memory port must
  // accept a write in every cycle that we_o is high, and words arrive back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wsel   <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mode_in == M_INSTR || mode_in == M_DATA) begin
            r_state  <= S_SHIFT;
            r_wsel   <= mode_in[1];
            r_addr   <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
          end else if (mode_in == M_RUN) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (mode_in != w_load_mode) begin
            // Abort wins over a completing word: the partial word is dropped.
            r_state  <= (mode_in == M_RUN) ? S_RUN : S_IDLE;
            r_run    <= (mode_in == M_RUN);
            r_busy   <= 1'b0;
            r_bitcnt <= '0;
          end else begin
            r_shift <= w_shift_next;
            if (w_word_end) begin
              r_wdata  <= w_shift_next;
              r_waddr  <= r_addr;
              r_we     <= 1'b1;
              r_bitcnt <= '0;
              r_addr   <= r_addr + ADDR_W'(1);
              if (w_last_word) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + BIT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (mode_in == M_IDLE) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else if (mode_in == M_RUN) begin
            r_state <= S_RUN;
            r_done  <= 1'b0;
            r_run   <= 1'b1;
          end
        end
        S_RUN: begin
          if (mode_in != M_RUN) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign we_o        = r_we;
  assign wsel_o      = r_wsel;
  assign waddr_o     = r_waddr;
  assign wdata_o     = r_wdata;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign run_o       = r_run;
  assign dbg_state_o = r_state;

endmodule
